note_scheduler: RTL and testbench

Controller that sits between the four piano keys and the square-wave tone generator. It synchronises and debounces the raw key lines and arbitrates between simultaneously held keys with last-pressed priority. It drives the selected note's half-period count to the generator, together with a 4-bit attack/sustain/release volume envelope that the sample path uses to scale its output.

---
 rtl/piano_pkg.sv | 24 ++
 rtl/key_debouncer.sv | 45 ++++
 rtl/note_scheduler.sv | 109 ++++++++++
 tb/tb_note_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared constants, note table and envelope state type for the note scheduler
package piano_pkg;

  localparam int NUM_KEYS = 4;
  localparam logic [3:0] VOL_MAX = 4'd15;

  // Generator half-period counts, index 0 = F4 .. index 3 = C4
  localparam int unsigned HALF_PERIOD [NUM_KEYS] = '{7163, 7576, 8503, 9542};

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  function automatic logic [1:0] top_index(input logic [NUM_KEYS-1:0] v);
    top_index = 2'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) top_index = 2'(i);
    end
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - two-flop synchroniser plus stability counter for one key line
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync2;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - key debounce, last-pressed arbitration and ASR volume envelope
module note_scheduler
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ENV_STEP        = 5000,
  parameter int HP_W            = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [1:0]          note_sel,
  output logic [HP_W-1:0]     half_period,
  output logic [3:0]          volume,
  output logic                note_active
);

  localparam int TW = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  env_state_e          state;
  logic [TW-1:0]       step_cnt;
  logic                step_fire;
  logic                press;
  logic                sel_released;
  logic [1:0]          press_idx;
  logic [1:0]          held_idx;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (keys[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign press        = |rise;
  assign press_idx    = top_index(rise);
  assign held_idx     = top_index(stable);
  assign step_fire    = (step_cnt == TW'(ENV_STEP - 1));
  assign sel_released = fall[note_sel] && (state == ENV_ATTACK || state == ENV_SUSTAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ENV_IDLE;
      step_cnt    <= '0;
      note_sel    <= 2'd0;
      half_period <= '0;
      volume      <= 4'd0;
      note_active <= 1'b0;
    end else begin
      if (press) begin
        note_sel    <= press_idx;
        half_period <= HP_W'(HALF_PERIOD[press_idx]);
        note_active <= 1'b1;
      end else if (sel_released && |stable) begin
        note_sel    <= held_idx;
        half_period <= HP_W'(HALF_PERIOD[held_idx]);
      end

      // A press outranks a simultaneous release; volume carries over on every transition
      if (press && state != ENV_ATTACK) begin
        state    <= ENV_ATTACK;
        step_cnt <= '0;
      end else if (!press && sel_released && !(|stable)) begin
        state    <= ENV_RELEASE;
        step_cnt <= '0;
      end else begin
        case (state)
          ENV_ATTACK: begin
            if (step_fire) begin
              step_cnt <= '0;
              if (volume >= VOL_MAX - 4'd1) begin
                volume <= VOL_MAX;
                state  <= ENV_SUSTAIN;
              end else begin
                volume <= volume + 4'd1;
              end
            end else begin
              step_cnt <= step_cnt + TW'(1);
            end
          end
          ENV_RELEASE: begin
            if (step_fire) begin
              step_cnt <= '0;
              if (volume <= 4'd1) begin
                volume      <= 4'd0;
                state       <= ENV_IDLE;
                note_active <= 1'b0;
                half_period <= '0;
              end else begin
                volume <= volume - 4'd1;
              end
            end else begin
              step_cnt <= step_cnt + TW'(1);
            end
          end
          default: step_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - scoreboard bench for note_scheduler with a cycle-level reference model
module tb_note_scheduler;

  localparam int D    = 4;
  localparam int STEP = 2;

  localparam int ST_IDLE = 0;
  localparam int ST_ATT  = 1;
  localparam int ST_SUS  = 2;
  localparam int ST_REL  = 3;

  typedef struct packed {
    logic [1:0]  sel;
    logic [13:0] hp;
    logic [3:0]  vol;
    logic        act;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  keys;
  logic [1:0]  note_sel;
  logic [13:0] half_period;
  logic [3:0]  volume;
  logic        note_active;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  int tb_hp [4] = '{7163, 7576, 8503, 9542};

  exp_t       expq[$];
  logic [3:0] rawq[$];
  logic [3:0] m_deb, m_pr, m_fl;
  int         m_st, m_vol, m_age, m_sel, m_hp;
  bit         m_act;
  bit         started = 0;

  note_scheduler #(.DEBOUNCE_CYCLES(D), .ENV_STEP(STEP), .HP_W(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys       (keys),
    .note_sel   (note_sel),
    .half_period(half_period),
    .volume     (volume),
    .note_active(note_active)
  );

  always #5 clk = ~clk;

  function automatic int highest_set(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_deb = 4'd0; m_pr = 4'd0; m_fl = 4'd0;
    rawq.delete();
    for (int i = 0; i < D + 2; i++) rawq.push_back(4'd0);
    m_st = ST_IDLE; m_vol = 0; m_age = 0; m_sel = 0; m_hp = 0; m_act = 0;
  endtask

  task automatic env_step();
    if (m_st == ST_ATT || m_st == ST_REL) begin
      m_age++;
      if (m_age == STEP) begin
        m_age = 0;
        if (m_st == ST_ATT) begin
          m_vol = (m_vol < 15) ? m_vol + 1 : 15;
          if (m_vol == 15) m_st = ST_SUS;
        end else begin
          m_vol = (m_vol > 0) ? m_vol - 1 : 0;
          if (m_vol == 0) begin m_st = ST_IDLE; m_act = 0; m_hp = 0; end
        end
      end
    end
  endtask

  task automatic model_step(input logic [3:0] raw);
    int  L;
    bit  all_diff;
    // Arbitration and envelope react to the debounce events of the previous edge
    if (m_pr != 0) begin
      m_sel = highest_set(m_pr); m_hp = tb_hp[m_sel];
      if (m_st == ST_ATT) env_step();
      else begin m_st = ST_ATT; m_age = 0; m_act = 1; end
    end else if ((m_st == ST_ATT || m_st == ST_SUS) && m_fl[m_sel]) begin
      if (m_deb != 0) begin m_sel = highest_set(m_deb); m_hp = tb_hp[m_sel]; env_step(); end
      else begin m_st = ST_REL; m_age = 0; end
    end else begin
      env_step();
    end
    // A key flips once its synced value has disagreed for D consecutive edges
    L = rawq.size();
    m_pr = 4'd0; m_fl = 4'd0;
    for (int k = 0; k < 4; k++) begin
      all_diff = 1;
      for (int j = 2; j <= D + 1; j++) if (rawq[L-j][k] == m_deb[k]) all_diff = 0;
      if (all_diff) begin
        m_deb[k] = ~m_deb[k];
        if (m_deb[k]) m_pr[k] = 1'b1; else m_fl[k] = 1'b1;
      end
    end
    rawq.push_back(raw);
    if (rawq.size() > D + 2) void'(rawq.pop_front());
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) model_reset();
    else model_step(keys);
    e.sel = 2'(m_sel); e.hp = 14'(m_hp); e.vol = 4'(m_vol); e.act = m_act;
    expq.push_back(e);
    started = 1;
    cycle++;
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (!rst_n) e = '0;
      a.sel = note_sel; a.hp = half_period; a.vol = volume; a.act = note_active;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard cycle=%0d actual sel=%0d hp=%0d vol=%0d act=%0d required sel=%0d hp=%0d vol=%0d act=%0d",
                 cycle, a.sel, a.hp, a.vol, a.act, e.sel, e.hp, e.vol, e.act);
      end
    end else if (started) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty cycle=%0d actual=0 required=1", cycle);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_sel"}, note_sel, 0);
    chk({name, "_hp"}, half_period, 0);
    chk({name, "_vol"}, volume, 0);
    chk({name, "_act"}, note_active, 0);
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    keys = k;
    repeat (n) tick();
  endtask

  initial begin
    int guard;
    int len;
    rst_n = 1'b0;
    keys  = 4'd0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    hold(4'b0000, 3);
    chk_zero("post_reset");

    hold(4'b1000, 7);
    chk("press3_sel", note_sel, 3);
    chk("press3_hp", half_period, 9542);
    chk("press3_act", note_active, 1);
    hold(4'b1000, 30);
    chk("attack_full", volume, 15);
    hold(4'b1000, 10);
    chk("sustain_hold", volume, 15);

    hold(4'b0000, 37);
    chk("release_vol", volume, 0);
    chk("release_act", note_active, 0);
    chk("release_hp", half_period, 0);

    hold(4'b1000, 40);
    hold(4'b1010, 7);
    chk("press1_sel", note_sel, 1);
    chk("press1_hp", half_period, 7576);
    hold(4'b1000, 7);
    chk("rel1_sel", note_sel, 3);
    chk("rel1_act", note_active, 1);
    chk("rel1_vol", volume, 15);

    hold(4'b1001, 2);
    hold(4'b1000, 10);
    chk("glitch_sel", note_sel, 3);

    hold(4'b0100, 7);
    chk("swap_sel", note_sel, 2);
    chk("swap_vol", volume, 15);
    chk("swap_hp", half_period, 8503);

    hold(4'b0000, 45);
    hold(4'b0101, 7);
    chk("dual_sel", note_sel, 2);
    hold(4'b0101, 40);

    keys = 4'b0000;
    guard = 0;
    while (volume != 4'd7 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_vol7", volume, 7);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    hold(4'b0000, 5);
    chk_zero("after_async_reset");

    for (int n = 0; n < 300; n++) begin
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
      hold(4'($urandom_range(0, 15)), len);
    end
    hold(4'b0000, 60);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
